// File: rtl/seq_alu_exec_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : ALU control codes shared with the control decoder, plus FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sll = 4'b0011;
    localparam logic [3:0] c_alu_srl = 4'b0100;
    localparam logic [3:0] c_alu_sra = 4'b0101;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_mul = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == c_alu_sll) || (code == c_alu_srl) || (code == c_alu_sra);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_exec_if.sv
// ============================================================================
// Module  : seq_alu_exec_if
// Brief   : Operand-side and result-side valid/ready bundle of the exec unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu_exec_alu_comb.sv
// ============================================================================
// Module  : alu_comb
// Brief   : Single-cycle AND/OR/ADD/SUB/SLT slice; o_legal low for other codes
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [3:0]       i_ctrl,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_y,
    output logic                  o_legal
);

    always_comb begin
        o_y     = '0;
        o_legal = 1'b1;
        case (i_ctrl)
            c_alu_and: o_y = i_a & i_b;
            c_alu_or:  o_y = i_a | i_b;
            c_alu_add: o_y = i_a + i_b;
            c_alu_sub: o_y = i_a - i_b;
            c_alu_slt: o_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu_exec.sv
// ============================================================================
// Module  : seq_alu_exec
// Brief   : Registered ALU with bit-serial shifts and shift-add multiply
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    seq_alu_exec_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    state_t           state_q,   state_d;
    logic [3:0]       op_q,      op_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             zero_q,    zero_d;
    logic             illegal_q, illegal_d;

    logic             w_accept;
    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_y;
    logic             w_legal;
    logic [WIDTH-1:0] w_fast;
    logic [WIDTH-1:0] w_step;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .i_ctrl  (bus.alu_ctrl),
        .i_a     (bus.op_a),
        .i_b     (bus.op_b),
        .o_y     (w_y),
        .o_legal (w_legal)
    );

    assign w_accept   = bus.in_valid && (state_q == S_IDLE);
    assign w_amt      = bus.op_b[SHW-1:0];
    assign w_is_shift = is_shift(bus.alu_ctrl);
    assign w_is_mul   = (MUL_EN != 1'b0) && (bus.alu_ctrl == c_alu_mul);
    assign w_fast     = w_legal ? w_y : '0;

    // One iteration of the serial datapath; MUL is the only non-shift op in EXEC.
    always_comb begin
        w_step = acc_q;
        case (op_q)
            c_alu_sll: w_step = acc_q << 1;
            c_alu_srl: w_step = acc_q >> 1;
            c_alu_sra: w_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default:   w_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d = bus.alu_ctrl;
                    if (w_is_shift && (w_amt != '0)) begin
                        acc_d   = bus.op_a;
                        cnt_d   = {1'b0, w_amt};
                        state_d = S_EXEC;
                    end else if (w_is_mul) begin
                        acc_d    = '0;
                        mcand_d  = bus.op_a;
                        mplier_d = bus.op_b;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_EXEC;
                    end else if (w_is_shift) begin
                        result_d  = bus.op_a;
                        zero_d    = (bus.op_a == '0);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        result_d  = w_fast;
                        zero_d    = (w_fast == '0);
                        illegal_d = !w_legal;
                        state_d   = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                acc_d    = w_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d  = w_step;
                    zero_d    = (w_step == '0);
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu_exec.sv
// ============================================================================
// Module  : tb_seq_alu_exec
// Brief   : Scoreboard bench: directed ops queue expectations, monitor compares
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu_exec;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        int          t_acc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_alu_exec_if #(.WIDTH(32)) bus ();
    seq_alu_exec_if #(.WIDTH(32)) bus_nm ();

    seq_alu_exec #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_alu_exec #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nm)
    );

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: first valid cycle checks value and latency, later cycles check hold.
    initial begin
        exp_t cur;
        bit   active;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid) begin
                if (!active) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_out: got result 0x%08h, expected no output", bus.result);
                    end else begin
                        cur    = sb_q[0];
                        active = 1'b1;
                        chk({cur.name, "_lat"}, 32'(cyc - cur.t_acc + 1), 32'(cur.lat));
                        chk({cur.name, "_res"}, bus.result, cur.res);
                        chk({cur.name, "_zero"}, {31'd0, bus.zero}, {31'd0, cur.z});
                        chk({cur.name, "_ill"}, {31'd0, bus.illegal}, {31'd0, cur.ill});
                    end
                end else begin
                    chk({cur.name, "_hold_res"}, bus.result, cur.res);
                    chk({cur.name, "_hold_zero"}, {31'd0, bus.zero}, {31'd0, cur.z});
                end
                if (bus.out_ready && active) begin
                    void'(sb_q.pop_front());
                    active = 1'b0;
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 just after the accept edge.
    task automatic issue(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic ill, input int lat, input bit push);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got in_ready 0, expected 1", name);
            return;
        end
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk); #1;
        if (push) begin
            e.name = name; e.res = res; e.z = z; e.ill = ill; e.lat = lat; e.t_acc = cyc;
            sb_q.push_back(e);
        end
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'b0010;
        bus.op_a     = 32'hDEAD_BEEF;
        bus.op_b     = 32'h0000_0003;
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        bus.in_valid     = 1'b0;
        bus.alu_ctrl     = 4'b0000;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.out_ready    = 1'b1;
        bus_nm.in_valid  = 1'b0;
        bus_nm.alu_ctrl  = 4'b0000;
        bus_nm.op_a      = '0;
        bus_nm.op_b      = '0;
        bus_nm.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.result,             32'd0);
        chk("rst_zero",      {31'd0, bus.zero},      32'd0);
        chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);

        issue("add",      c_alu_add, 32'h5,         32'h3,         32'h8,         1'b0, 1'b0, 1, 1'b1);
        issue("sub",      c_alu_sub, 32'h7,         32'h7,         32'h0,         1'b1, 1'b0, 1, 1'b1);
        issue("slt_neg",  c_alu_slt, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1, 1'b1);
        issue("slt_pos",  c_alu_slt, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1, 1'b1);
        issue("and",      c_alu_and, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1, 1'b1);
        issue("or",       c_alu_or,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1, 1'b1);
        issue("add_wrap", c_alu_add, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1, 1'b1);
        issue("sra4",     c_alu_sra, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1'b0, 5, 1'b1);
        issue("srl31",    c_alu_srl, 32'h8000_0000, 32'h1F,        32'h1,         1'b0, 1'b0, 32, 1'b1);
        issue("sll_amt1", c_alu_sll, 32'h1,         32'h21,        32'h2,         1'b0, 1'b0, 2, 1'b1);
        issue("sll_amt0", c_alu_sll, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 1, 1'b1);
        issue("srl_b32",  c_alu_srl, 32'h8765_4321, 32'h20,        32'h8765_4321, 1'b0, 1'b0, 1, 1'b1);
        issue("ill_f",    4'b1111,   32'h5,         32'h3,         32'h0,         1'b1, 1'b1, 1, 1'b1);
        issue("ill_9",    4'b1001,   32'h5,         32'h3,         32'h0,         1'b1, 1'b1, 1, 1'b1);

        // MUL while a competing op is held valid for most of the EXEC phase.
        issue("mul", c_alu_mul, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 1'b0, 33, 1'b1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c_alu_add;
        bus.op_a     = 32'h1;
        bus.op_b     = 32'h1;
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.in_ready) busy++;
            @(posedge clk); #2;
        end
        bus.in_valid = 1'b0;
        chk("mul_in_ready_busy", 32'(busy), 32'd0);
        issue("mul_wrap", c_alu_mul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 33, 1'b1);
        drain();

        // Backpressure: result held for several cycles, then released.
        bus.out_ready = 1'b0;
        issue("bp_add", c_alu_add, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1, 1'b1);
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_not_ready",  {31'd0, bus.in_ready},  32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_in_ready_after", {31'd0, bus.in_ready},  32'd1);
        chk("bp_valid_dropped",  {31'd0, bus.out_valid}, 32'd0);
        drain();

        // MUL_EN=0 instance: MUL code reports illegal in one cycle.
        bus_nm.in_valid = 1'b1;
        bus_nm.alu_ctrl = c_alu_mul;
        bus_nm.op_a     = 32'h3;
        bus_nm.op_b     = 32'h5;
        @(posedge clk); #1;
        bus_nm.in_valid = 1'b0;
        @(negedge clk);
        chk("nomul_valid",   {31'd0, bus_nm.out_valid}, 32'd1);
        chk("nomul_illegal", {31'd0, bus_nm.illegal},   32'd1);
        chk("nomul_result",  bus_nm.result,             32'd0);
        chk("nomul_zero",    {31'd0, bus_nm.zero},      32'd1);
        @(posedge clk); #2;

        // Reset during EXEC cycle 10 of a MUL: aborted op must never complete.
        issue("mul_abort", c_alu_mul, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (9) begin
            @(posedge clk); #2;
        end
        reset = 1'b1;
        @(posedge clk); #2;
        chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_result",    bus.result,             32'd0);
        reset = 1'b0;
        issue("add_after_abort", c_alu_add, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1, 1'b1);
        drain();
        repeat (40) begin
            @(posedge clk); #2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
